load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory stage of the RV32 core, directly downstream of register_file.
- Takes the ALU-computed address and regB_data (store source), and runs one data-memory transaction per load/store over a req/ack handshake.
- Formats load data (byte/halfword extract, sign/zero extend) and produces the write-back triple (enable, rd, data) that register_file consumes.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, number of cycles to wait for dm_ack before aborting with fault; range 1..255 (8-bit counter).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  current instruction is a load
- mem_write  in  1  current instruction is a store
- funct3  in  3  RV32 width/sign field
- address  in  32  effective byte address from ALU
- store_data  in  32  regB_data
- rd_address  in  5  load destination register
- dm_req_read  out  1  data-memory read request
- dm_req_write  out  1  data-memory write request
- dm_addr  out  32  word-aligned address {address[31:2],2'b00}
- dm_wdata  out  32  lane-replicated store data
- dm_byte_en  out  4  byte lanes
- dm_ack  in  1  memory completion, single-cycle pulse
- dm_rdata  in  32  read word, valid with dm_ack
- stall  out  1  hold upstream pipeline
- wb_en  out  1  register write enable (one-cycle pulse)
- wb_rd_address  out  5  write-back destination
- wb_data  out  32  formatted load data
- fault  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Reset: state=IDLE. All outputs are 0: dm_req_*, dm_addr, dm_wdata, dm_byte_en, wb_en, wb_rd_address, wb_data, fault, timeout counter. stall=0.
- States: IDLE, WAIT, DONE.
- IDLE:
  - An access is a cycle with mem_read|mem_write. If both are asserted, the read wins and the write is dropped.
  - On a legal, aligned access, register the request fields (dm_addr, dm_wdata, dm_byte_en, rd, funct3, addr[1:0], read/write) and go to WAIT. stall=1 combinationally in that same cycle.
  - On an illegal access (funct3 not in {000,001,010,100,101} for loads, not in {000,001,010} for stores), or a misaligned one (halfword with addr[0]=1, word with addr[1:0]!=0): pulse fault next cycle, issue no memory request, stay in IDLE. stall=0.
- WAIT:
  - dm_req_read or dm_req_write is held at 1 with stable addr/wdata/byte_en until dm_ack. stall=1.
  - Counter increments each WAIT cycle.
  - On dm_ack: capture and format dm_rdata, deassert the request, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES with no ack: deassert the request, pulse fault, go to IDLE. No wb_en.
- DONE (exactly one cycle):
  - stall=0.
  - wb_en=1 for loads only; 0 for stores.
  - Inputs are ignored, so no re-issue of the instruction still presented.
  - Next state is IDLE.
- Latency: access in cycle N; request visible from N+1; ack in cycle M gives wb_en in M+1. Minimum is 3 cycles from IDLE access to DONE (ack at N+1).
- Store lanes:
  - SB: byte_en=1<<addr[1:0], wdata={4{sd[7:0]}}
  - SH: byte_en=addr[1]?1100:0011, wdata={2{sd[15:0]}}
  - SW: byte_en=1111, wdata=sd
- Load format:
  - LB/LBU: select byte addr[1:0], then sign- or zero-extend.
  - LH/LHU: select half addr[1], then sign- or zero-extend.
  - LW: pass through.
- dm_ack outside WAIT is ignored.
- rst in any state returns to IDLE next edge with all outputs cleared. An in-flight transaction is abandoned, with no wb_en and no fault.

Decomposition:
- Shared package lsu_pkg holds:
  - typedef enum lsu_state_t {IDLE,WAIT,DONE}
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101
- One combinational sub-module, load_formatter (inputs rdata, funct3, addr[1:0]; output 32-bit result), reused by the verification model.

Test Plan:
- LW at 0x100, memory acks at N+1 with rdata 0xDEADBEEF, rd=5 -> dm_req_read N+1 only, dm_byte_en=1111, wb_en=1 at N+2, wb_rd_address=5, wb_data=0xDEADBEEF, stall high N..N+1.
- LB at 0x103 with rdata 0x80FF_7F01 -> wb_data=0xFFFFFF80; LBU same -> 0x00000080; LHU at 0x102 -> 0x000080FF; LH at 0x100 -> 0x00007F01.
- SH at 0x206, store_data 0x1234ABCD, ack delayed 4 cycles -> dm_addr=0x204, byte_en=1100, wdata=0xABCDABCD held stable 4 cycles, stall for 5 cycles, wb_en never 1.
- LW at 0x101 -> fault pulse next cycle, dm_req_read never 1, stall 0. Store with funct3=011 -> fault, no request.
- TIMEOUT_CYCLES=4, no ack -> request high 4 cycles, then deasserts, fault pulses, returns to IDLE, no wb_en. A late dm_ack afterwards is ignored.
- rst asserted during WAIT -> next cycle all outputs 0, state IDLE. A new LW then completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
// access_ok() decides legality and alignment of an access.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic access_ok(
      input logic       is_load,
      input logic [2:0] f3,
      input logic [1:0] lo
   );
      logic ok;
      ok = 1'b0;
      unique case (1'b1)
         (f3 == F3_B):  ok = 1'b1;
         (f3 == F3_H):  ok = ~lo[0];
         (f3 == F3_W):  ok = (lo == 2'b00);
         (f3 == F3_BU): ok = is_load;
         (f3 == F3_HU): ok = is_load & ~lo[0];
         default:       ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_formatter.sv
// Extracts the addressed byte/halfword from a read word
// and sign- or zero-extends it.
module load_formatter
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   output logic [31:0] result
);

   logic [31:0] shifted;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign shifted = rdata >> {addr_lo, 3'b000};
   assign byte_v  = shifted[7:0];
   assign half_v  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      result = rdata;
      unique case (1'b1)
         (funct3 == F3_B):  result = {{24{byte_v[7]}}, byte_v};
         (funct3 == F3_BU): result = {24'h0, byte_v};
         (funct3 == F3_H):  result = {{16{half_v[15]}}, half_v};
         (funct3 == F3_HU): result = {16'h0, half_v};
         default:           result = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one req/ack data-memory transaction per load/store,
// load formatting, write-back triple and pipeline stall.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] address,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd_address,
   output logic        dm_req_read,
   output logic        dm_req_write,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_byte_en,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        stall,
   output logic        wb_en,
   output logic [4:0]  wb_rd_address,
   output logic [31:0] wb_data,
   output logic        fault
);

   lsu_state_t  state;
   logic [7:0]  tmo_cnt;
   logic        is_load_q;
   logic [2:0]  f3_q;
   logic [1:0]  lo_q;
   logic [4:0]  rd_q;
   logic        access;
   logic        ok;
   logic [3:0]  be_n;
   logic [31:0] wd_n;
   logic [31:0] fmt;

   // read wins when both strobes are set
   assign access = mem_read | mem_write;
   assign ok     = access_ok(mem_read, funct3, address[1:0]);
   assign stall  = (state == WAIT) ||
                   ((state == IDLE) && access && ok);

   always_comb begin
      be_n = 4'b1111;
      wd_n = store_data;
      unique case (1'b1)
         (funct3[1:0] == 2'b00): begin
            be_n = 4'b0001 << address[1:0];
            wd_n = {4{store_data[7:0]}};
         end
         (funct3[1:0] == 2'b01): begin
            be_n = address[1] ? 4'b1100 : 4'b0011;
            wd_n = {2{store_data[15:0]}};
         end
         default: ;
      endcase
   end

   load_formatter u_fmt (
      .rdata   (dm_rdata),
      .funct3  (f3_q),
      .addr_lo (lo_q),
      .result  (fmt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         tmo_cnt       <= 8'd0;
         is_load_q     <= 1'b0;
         f3_q          <= 3'd0;
         lo_q          <= 2'd0;
         rd_q          <= 5'd0;
         dm_req_read   <= 1'b0;
         dm_req_write  <= 1'b0;
         dm_addr       <= 32'd0;
         dm_wdata      <= 32'd0;
         dm_byte_en    <= 4'd0;
         wb_en         <= 1'b0;
         wb_rd_address <= 5'd0;
         wb_data       <= 32'd0;
         fault         <= 1'b0;
      end else begin
         fault <= 1'b0;
         wb_en <= 1'b0;
         unique case (state)
            IDLE: begin
               if (access && ok) begin
                  dm_req_read  <= mem_read;
                  dm_req_write <= ~mem_read;
                  dm_addr      <= {address[31:2], 2'b00};
                  dm_wdata     <= wd_n;
                  dm_byte_en   <= be_n;
                  is_load_q    <= mem_read;
                  f3_q         <= funct3;
                  lo_q         <= address[1:0];
                  rd_q         <= rd_address;
                  tmo_cnt      <= 8'd0;
                  state        <= WAIT;
               end else if (access) begin
                  fault <= 1'b1;
               end
            end
            WAIT: begin
               // an ack on the last allowed cycle still completes
               if (dm_ack) begin
                  dm_req_read   <= 1'b0;
                  dm_req_write  <= 1'b0;
                  wb_en         <= is_load_q;
                  wb_rd_address <= rd_q;
                  if (is_load_q) wb_data <= fmt;
                  state         <= DONE;
               end else if (tmo_cnt + 8'd1 == 8'(TIMEOUT_CYCLES)) begin
                  dm_req_read  <= 1'b0;
                  dm_req_write <= 1'b0;
                  fault        <= 1'b1;
                  tmo_cnt      <= 8'd0;
                  state        <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT_CYCLES=4.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] address = 32'd0;
   logic [31:0] store_data = 32'd0;
   logic [4:0]  rd_address = 5'd0;
   logic        dm_req_read;
   logic        dm_req_write;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_byte_en;
   logic        dm_ack = 1'b0;
   logic [31:0] dm_rdata = 32'd0;
   logic        stall;
   logic        wb_en;
   logic [4:0]  wb_rd_address;
   logic [31:0] wb_data;
   logic        fault;

   int cmp = 0;
   int bad = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .address(address),
      .store_data(store_data), .rd_address(rd_address),
      .dm_req_read(dm_req_read), .dm_req_write(dm_req_write),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_byte_en(dm_byte_en), .dm_ack(dm_ack),
      .dm_rdata(dm_rdata), .stall(stall),
      .wb_en(wb_en), .wb_rd_address(wb_rd_address),
      .wb_data(wb_data), .fault(fault)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_load(
      input  logic [2:0]  f3,
      input  logic [31:0] a,
      input  logic [31:0] rdata,
      output logic [31:0] got,
      output logic        got_en
   );
      step();
      mem_read = 1'b1; funct3 = f3; address = a; rd_address = 5'd7;
      step();
      mem_read = 1'b0; dm_ack = 1'b1; dm_rdata = rdata;
      step();
      dm_ack = 1'b0;
      got = wb_data;
      got_en = wb_en;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      cmp++;
      if ({dm_req_read, dm_req_write, dm_byte_en} !== 6'd0) begin
         bad++;
         $display("FAIL reset_req: got %b want 0",
                  {dm_req_read, dm_req_write, dm_byte_en});
      end
      cmp++;
      if ({dm_addr, dm_wdata, wb_data} !== 96'd0) begin
         bad++;
         $display("FAIL reset_data: got %h want 0",
                  {dm_addr, dm_wdata, wb_data});
      end
      cmp++;
      if ({wb_en, wb_rd_address, fault, stall} !== 8'd0) begin
         bad++;
         $display("FAIL reset_ctl: got %b want 0",
                  {wb_en, wb_rd_address, fault, stall});
      end
      rst = 1'b0;
   endtask

   task automatic test_lw();
      step();
      mem_read = 1'b1; funct3 = F3_W; address = 32'h100; rd_address = 5'd5;
      #1;
      cmp++;
      if (stall !== 1'b1) begin
         bad++; $display("FAIL lw_stall_n: got %b want 1", stall);
      end
      step();
      dm_ack = 1'b1; dm_rdata = 32'hDEADBEEF;
      cmp++;
      if ({dm_req_read, dm_req_write, dm_byte_en, stall} !== 7'b1011111) begin
         bad++;
         $display("FAIL lw_req: got %b want 1011111",
                  {dm_req_read, dm_req_write, dm_byte_en, stall});
      end
      cmp++;
      if (dm_addr !== 32'h100) begin
         bad++; $display("FAIL lw_addr: got %h want 00000100", dm_addr);
      end
      step();
      dm_ack = 1'b0;
      cmp++;
      if ({dm_req_read, wb_en, wb_rd_address, stall} !== 8'b0_1_00101_0) begin
         bad++;
         $display("FAIL lw_wb: got %b want 01001010",
                  {dm_req_read, wb_en, wb_rd_address, stall});
      end
      cmp++;
      if (wb_data !== 32'hDEADBEEF) begin
         bad++; $display("FAIL lw_data: got %h want deadbeef", wb_data);
      end
      step();
      mem_read = 1'b0;
      cmp++;
      if ({dm_req_read, wb_en} !== 2'b00) begin
         bad++;
         $display("FAIL lw_done_ignore: got %b want 00", {dm_req_read, wb_en});
      end
      step();
      cmp++;
      if ({dm_req_read, stall} !== 2'b00) begin
         bad++;
         $display("FAIL lw_no_reissue: got %b want 00", {dm_req_read, stall});
      end
   endtask

   task automatic test_load_format();
      logic [2:0]  f3v [6];
      logic [31:0] av  [6];
      logic [31:0] exp [6];
      logic [31:0] got;
      logic        en;
      f3v = '{F3_B, F3_BU, F3_HU, F3_H, F3_H, F3_B};
      av  = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h102, 32'h100};
      exp = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF,
              32'h00007F01, 32'hFFFF80FF, 32'h00000001};
      for (int i = 0; i < 6; i++) begin
         run_load(f3v[i], av[i], 32'h80FF7F01, got, en);
         cmp++;
         if ({en, got} !== {1'b1, exp[i]}) begin
            bad++;
            $display("FAIL fmt_%0d: got en=%b %h want en=1 %h",
                     i, en, got, exp[i]);
         end
      end
   endtask

   task automatic test_store_sh();
      int stalls;
      stalls = 0;
      step();
      mem_write = 1'b1; funct3 = F3_H; address = 32'h206;
      store_data = 32'h1234ABCD;
      #1;
      if (stall) stalls++;
      for (int i = 1; i <= 4; i++) begin
         step();
         mem_write = 1'b0;
         if (stall) stalls++;
         cmp++;
         if ({dm_req_write, dm_req_read, dm_byte_en, wb_en} !== 7'b1011000 ||
             dm_addr !== 32'h204 || dm_wdata !== 32'hABCDABCD) begin
            bad++;
            $display("FAIL sh_wait%0d: got %b %h %h want 1011000 204 abcdabcd",
                     i, {dm_req_write, dm_req_read, dm_byte_en, wb_en},
                     dm_addr, dm_wdata);
         end
         if (i == 4) dm_ack = 1'b1;
      end
      step();
      dm_ack = 1'b0;
      if (stall) stalls++;
      cmp++;
      if ({dm_req_write, wb_en, stall} !== 3'b000) begin
         bad++;
         $display("FAIL sh_done: got %b want 000",
                  {dm_req_write, wb_en, stall});
      end
      step();
      cmp++;
      if ({wb_en, stalls[3:0]} !== {1'b0, 4'd5}) begin
         bad++;
         $display("FAIL sh_stalls: got wb_en=%b stalls=%0d want 0 5",
                  wb_en, stalls);
      end
   endtask

   task automatic test_store_lanes();
      step();
      mem_write = 1'b1; funct3 = F3_B; address = 32'h301;
      store_data = 32'h000000A5;
      step();
      mem_write = 1'b0; dm_ack = 1'b1;
      cmp++;
      if ({dm_byte_en, dm_wdata, dm_addr} !== {4'b0010, 32'hA5A5A5A5, 32'h300}) begin
         bad++;
         $display("FAIL sb_lanes: got %b %h %h want 0010 a5a5a5a5 300",
                  dm_byte_en, dm_wdata, dm_addr);
      end
      step();
      dm_ack = 1'b0;
      step();
      mem_write = 1'b1; funct3 = F3_W; address = 32'h304;
      store_data = 32'hCAFEF00D;
      step();
      mem_write = 1'b0; dm_ack = 1'b1;
      cmp++;
      if ({dm_byte_en, dm_wdata} !== {4'b1111, 32'hCAFEF00D}) begin
         bad++;
         $display("FAIL sw_lanes: got %b %h want 1111 cafef00d",
                  dm_byte_en, dm_wdata);
      end
      step();
      dm_ack = 1'b0;
   endtask

   task automatic test_fault();
      step();
      mem_read = 1'b1; funct3 = F3_W; address = 32'h101;
      #1;
      cmp++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL mis_stall: got %b want 0", stall);
      end
      step();
      mem_read = 1'b0;
      cmp++;
      if ({fault, dm_req_read, stall} !== 3'b100) begin
         bad++;
         $display("FAIL mis_fault: got %b want 100",
                  {fault, dm_req_read, stall});
      end
      step();
      cmp++;
      if ({fault, dm_req_read} !== 2'b00) begin
         bad++;
         $display("FAIL mis_after: got %b want 00", {fault, dm_req_read});
      end
      mem_write = 1'b1; funct3 = 3'b011; address = 32'h200;
      #1;
      cmp++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL ill_stall: got %b want 0", stall);
      end
      step();
      mem_write = 1'b0;
      cmp++;
      if ({fault, dm_req_write} !== 2'b10) begin
         bad++;
         $display("FAIL ill_fault: got %b want 10", {fault, dm_req_write});
      end
      step();
      cmp++;
      if ({fault, dm_req_write} !== 2'b00) begin
         bad++;
         $display("FAIL ill_after: got %b want 00", {fault, dm_req_write});
      end
   endtask

   task automatic test_read_wins();
      step();
      mem_read = 1'b1; mem_write = 1'b1; funct3 = F3_W; address = 32'h400;
      step();
      mem_read = 1'b0; mem_write = 1'b0; dm_ack = 1'b1;
      cmp++;
      if ({dm_req_read, dm_req_write} !== 2'b10) begin
         bad++;
         $display("FAIL read_wins: got %b want 10",
                  {dm_req_read, dm_req_write});
      end
      step();
      dm_ack = 1'b0;
   endtask

   task automatic test_timeout();
      step();
      mem_read = 1'b1; funct3 = F3_W; address = 32'h500;
      for (int i = 1; i <= 4; i++) begin
         step();
         mem_read = 1'b0;
         cmp++;
         if ({dm_req_read, fault, stall} !== 3'b101) begin
            bad++;
            $display("FAIL tmo_wait%0d: got %b want 101",
                     i, {dm_req_read, fault, stall});
         end
      end
      step();
      dm_ack = 1'b1;
      cmp++;
      if ({dm_req_read, fault, wb_en, stall} !== 4'b0100) begin
         bad++;
         $display("FAIL tmo_fault: got %b want 0100",
                  {dm_req_read, fault, wb_en, stall});
      end
      step();
      dm_ack = 1'b0;
      cmp++;
      if ({dm_req_read, fault, wb_en, stall} !== 4'b0000) begin
         bad++;
         $display("FAIL tmo_late_ack: got %b want 0000",
                  {dm_req_read, fault, wb_en, stall});
      end
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] got;
      logic        en;
      step();
      mem_read = 1'b1; funct3 = F3_W; address = 32'h600; rd_address = 5'd9;
      step();
      mem_read = 1'b0;
      cmp++;
      if (dm_req_read !== 1'b1) begin
         bad++; $display("FAIL rst_pre: got %b want 1", dm_req_read);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      cmp++;
      if ({dm_req_read, dm_req_write, dm_byte_en, wb_en, fault, stall} !== 9'd0 ||
          {dm_addr, dm_wdata, wb_data, wb_rd_address} !== 101'd0) begin
         bad++;
         $display("FAIL rst_wait: got %b %h %h %h %h want all 0",
                  {dm_req_read, dm_req_write, dm_byte_en, wb_en, fault, stall},
                  dm_addr, dm_wdata, wb_data, wb_rd_address);
      end
      dm_ack = 1'b1;
      step();
      dm_ack = 1'b0;
      cmp++;
      if ({wb_en, fault} !== 2'b00) begin
         bad++; $display("FAIL rst_abandon: got %b want 00", {wb_en, fault});
      end
      run_load(F3_W, 32'h700, 32'h55AA55AA, got, en);
      cmp++;
      if ({en, got} !== {1'b1, 32'h55AA55AA}) begin
         bad++;
         $display("FAIL rst_recover: got en=%b %h want en=1 55aa55aa", en, got);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_format();
      test_store_sh();
      test_store_lanes();
      test_fault();
      test_read_wins();
      test_timeout();
      test_reset_in_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end

endmodule
